// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, frame error and break detection
module uart_rx #(
    parameter int CLK_COUNT = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BIT  = 3'd2,
        STOP_BIT  = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam logic [12:0] HALF_M1 = 13'(CLK_COUNT / 2 - 1);
    localparam logic [12:0] FULL_M1 = 13'(CLK_COUNT - 1);

    state_t      state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_sync_q, rx_sync_d;

    always_comb begin
        rx_meta_d = i_rx;
        rx_sync_d = rx_meta_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_sync_q) begin
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    // A line that is high again at mid-start was only a glitch.
                    state_d = rx_sync_q ? IDLE : DATA_BIT;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            DATA_BIT: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_sync_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP_BIT;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            STOP_BIT: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_sync_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            WAIT_HIGH: begin
                // Break: ignore the line until it returns high.
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != IDLE);

endmodule
